// File: rtl/video_timing_pkg.sv
// -----------------------------------------------------------------------------
// video_timing_pkg
// Shared definitions for the HDMI-side video timing generator:
//   - counter width used by counterX / counterY
//   - sequencer state encoding (IDLE / RUN)
//   - per-mode timing constants (480p, 240p line-doubled onto a 480p raster)
//   - in_window(): inclusive-start / exclusive-end range test on counters
// Optional feature macro used by the generator: VTG_PIXEL_REPEAT_EN.
// -----------------------------------------------------------------------------
package video_timing_pkg;

  // Width of the raw horizontal / vertical timing counters.
  localparam int CNT_W = 12;

  // Sequencer states.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Timing of one output mode, in pixels (horizontal) and lines (vertical).
  typedef struct packed {
    logic [CNT_W-1:0] h_active;
    logic [CNT_W-1:0] h_fp;
    logic [CNT_W-1:0] h_sync;
    logic [CNT_W-1:0] h_bp;
    logic [CNT_W-1:0] v_active;
    logic [CNT_W-1:0] v_fp;
    logic [CNT_W-1:0] v_sync;
    logic [CNT_W-1:0] v_bp;
  } vtg_mode_t;

  // CEA 720x480p60.
  localparam vtg_mode_t MODE_480P = '{
    h_active: 12'd720, h_fp: 12'd16, h_sync: 12'd62, h_bp: 12'd60,
    v_active: 12'd480, v_fp: 12'd9,  v_sync: 12'd6,  v_bp: 12'd30
  };

  // 240p source shown line-doubled: the output raster is the 480p raster,
  // every source line is emitted twice (line_doubler = 1).
  localparam vtg_mode_t MODE_240P_X2 = MODE_480P;
  localparam int        SRC_LINES_240P = 240;

  // True when lo <= value < lo + len (sum kept one bit wider to avoid wrap).
  function automatic logic in_window(input logic [CNT_W-1:0] value,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] len);
    logic [CNT_W:0] hi;
    hi = {1'b0, lo} + {1'b0, len};
    return ({1'b0, value} >= {1'b0, lo}) && ({1'b0, value} < hi);
  endfunction

endpackage

// File: rtl/video_timing_gen_sync_delay.sv
// -----------------------------------------------------------------------------
// sync_delay
// DEPTH-stage shift register that delays hsync / vsync / DrawArea so they line
// up with the RAM read data of the address issued DEPTH cycles earlier.
// Every stage resets to the inactive level of its signal.
// Ports:
//   clock_i           clock
//   rst_ni            asynchronous active-low reset (already deassert-synced)
//   hs_i, vs_i, de_i  undelayed timing
//   hs_o, vs_o, de_o  timing delayed by DEPTH cycles
// -----------------------------------------------------------------------------
module sync_delay
  import video_timing_pkg::*;
#(
  parameter int   DEPTH   = 2,
  parameter logic HS_IDLE = 1'b1,
  parameter logic VS_IDLE = 1'b1
) (
  input  logic clock_i,
  input  logic rst_ni,
  input  logic hs_i,
  input  logic vs_i,
  input  logic de_i,
  output logic hs_o,
  output logic vs_o,
  output logic de_o
);

  logic [DEPTH-1:0] hs_q;
  logic [DEPTH-1:0] vs_q;
  logic [DEPTH-1:0] de_q;

  // Shift the three timing bits one stage per clock.
  always_ff @(posedge clock_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hs_q <= {DEPTH{HS_IDLE}};
      vs_q <= {DEPTH{VS_IDLE}};
      de_q <= {DEPTH{1'b0}};
    end else begin
      hs_q[0] <= hs_i;
      vs_q[0] <= vs_i;
      de_q[0] <= de_i;
      for (int i = 1; i < DEPTH; i++) begin
        hs_q[i] <= hs_q[i-1];
        vs_q[i] <= vs_q[i-1];
        de_q[i] <= de_q[i-1];
      end
    end
  end

  assign hs_o = hs_q[DEPTH-1];
  assign vs_o = vs_q[DEPTH-1];
  assign de_o = de_q[DEPTH-1];

endmodule

// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
// HDMI-side output timing generator and ring-buffer read sequencer.
// Waits in IDLE for the buffer-ready trigger, then runs free: produces raw
// counters, a frame_start pulse, a ring-buffer read address and the
// hsync / vsync / DrawArea timing delayed by RD_LATENCY to match RAM q.
//
// Optional feature macro: VTG_PIXEL_REPEAT_EN
//   defined   : pixel_repeat honoured (each buffer pixel read twice)
//   undefined : pixel_repeat ignored, behaves as pixel_repeat = 0
//
// Ports:
//   clock         hdmi_clock
//   reset         asynchronous active-low reset (deassert synced internally)
//   starttrigger  buffer-ready flag, only looked at in IDLE
//   line_doubler  1 = each source line shown twice   (latched per frame)
//   add_line      1 = frame is one line longer       (latched per frame)
//   pixel_repeat  1 = horizontal pixel doubling      (latched per frame)
//   rdaddr        ring-buffer read address, aligned with counterX/counterY
//   hsync, vsync, DrawArea  timing delayed by RD_LATENCY
//   counterX, counterY      raw timing counters
//   frame_start   one-cycle pulse while the counters sit at (0,0)
// -----------------------------------------------------------------------------
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int   H_ACTIVE         = int'(MODE_480P.h_active),
  parameter int   H_FP             = int'(MODE_480P.h_fp),
  parameter int   H_SYNC           = int'(MODE_480P.h_sync),
  parameter int   H_BP             = int'(MODE_480P.h_bp),
  parameter int   V_ACTIVE         = int'(MODE_480P.v_active),
  parameter int   V_FP             = int'(MODE_480P.v_fp),
  parameter int   V_SYNC           = int'(MODE_480P.v_sync),
  parameter int   V_BP             = int'(MODE_480P.v_bp),
  parameter logic HSYNC_POL        = 1'b0,
  parameter logic VSYNC_POL        = 1'b0,
  parameter int   BUFFER_LINES     = 4,
  parameter int   RAM_ADDRESS_BITS = 12,
  parameter int   RD_LATENCY       = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        starttrigger,
  input  logic                        line_doubler,
  input  logic                        add_line,
  input  logic                        pixel_repeat,
  output logic [RAM_ADDRESS_BITS-1:0] rdaddr,
  output logic                        hsync,
  output logic                        vsync,
  output logic                        DrawArea,
  output logic [CNT_W-1:0]            counterX,
  output logic [CNT_W-1:0]            counterY,
  output logic                        frame_start
);

  localparam int AW        = RAM_ADDRESS_BITS;
  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BUF_WORDS = BUFFER_LINES * H_ACTIVE;

  localparam logic [CNT_W-1:0] H_LAST      = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST      = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_C     = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C     = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START    = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LEN      = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] VS_START    = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LEN      = CNT_W'(V_SYNC);
  localparam logic [AW:0]      BUF_LIMIT   = (AW+1)'(BUF_WORDS);
  localparam logic [AW:0]      STEP_FULL   = (AW+1)'(H_ACTIVE);
  localparam logic [AW:0]      STEP_HALF   = (AW+1)'(H_ACTIVE / 2);

  // ---------------------------------------------------------------------------
  // Reset: asserts asynchronously, releases two clocks after the pin does.
  // ---------------------------------------------------------------------------
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  // Two-flop reset release synchroniser.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_q[1];

  // ---------------------------------------------------------------------------
  // Pixel-repeat request, compiled in only with the feature enabled.
  // ---------------------------------------------------------------------------
  logic pr_in_s;
`ifdef VTG_PIXEL_REPEAT_EN
  assign pr_in_s = pixel_repeat;
`else
  logic unused_pixel_repeat;
  assign unused_pixel_repeat = pixel_repeat;
  assign pr_in_s             = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [0:0]       state_q,     state_d;
  logic [CNT_W-1:0] x_q,         x_d;
  logic [CNT_W-1:0] y_q,         y_d;
  logic             fs_q,        fs_d;
  logic             ld_q,        ld_d;
  logic             al_q,        al_d;
  logic             pr_q,        pr_d;
  logic [AW-1:0]    line_base_q, line_base_d;
  logic [AW-1:0]    rdaddr_q,    rdaddr_d;

  logic [CNT_W-1:0] v_last_s;
  logic [AW:0]      base_step_s;
  logic [AW:0]      base_sum_s;
  logic [AW-1:0]    x_off_s;

  // Last line index of the frame; add_line appends one line after back porch.
  assign v_last_s = al_q ? (V_LAST + CNT_W'(1)) : V_LAST;

  // Buffer offset of the next source line (pixel repeat halves the line).
  assign base_step_s = pr_q ? STEP_HALF : STEP_FULL;
  assign base_sum_s  = {1'b0, line_base_q} + base_step_s;

  // Sequencer, counters, per-frame mode latches and ring-buffer line base.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    fs_d        = 1'b0;
    ld_d        = ld_q;
    al_d        = al_q;
    pr_d        = pr_q;
    line_base_d = line_base_q;
    case (state_q)
      ST_IDLE: begin
        if (starttrigger) begin
          state_d     = ST_RUN;
          x_d         = '0;
          y_d         = '0;
          fs_d        = 1'b1;
          ld_d        = line_doubler;
          al_d        = add_line;
          pr_d        = pr_in_s;
          line_base_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (x_q == H_LAST) begin
          x_d = '0;
          if (y_q == v_last_s) begin
            y_d         = '0;
            fs_d        = 1'b1;
            ld_d        = line_doubler;
            al_d        = add_line;
            pr_d        = pr_in_s;
            line_base_d = '0;
          end else begin
            y_d = y_q + CNT_W'(1);
            // With line doubling the base only moves after the odd line.
            if (!ld_q || y_q[0]) begin
              line_base_d = (base_sum_s >= BUF_LIMIT) ? '0 : base_sum_s[AW-1:0];
            end else begin
              line_base_d = line_base_q;
            end
          end
        end else begin
          x_d = x_q + CNT_W'(1);
        end
      end
      default: begin
        state_d     = ST_IDLE;
        x_d         = '0;
        y_d         = '0;
        line_base_d = '0;
      end
    endcase
  end

  // Horizontal offset into the buffer line for the next pixel.
  assign x_off_s = pr_d ? AW'(x_d >> 1) : AW'(x_d);

  // Read address follows the next counter position; held outside active video.
  always_comb begin
    if ((state_d == ST_RUN) && (x_d < H_ACT_C) && (y_d < V_ACT_C)) begin
      rdaddr_d = line_base_d + x_off_s;
    end else begin
      rdaddr_d = rdaddr_q;
    end
  end

  // Sequencer and address registers.
  always_ff @(posedge clock or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      fs_q        <= 1'b0;
      ld_q        <= 1'b0;
      al_q        <= 1'b0;
      pr_q        <= 1'b0;
      line_base_q <= '0;
      rdaddr_q    <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      fs_q        <= fs_d;
      ld_q        <= ld_d;
      al_q        <= al_d;
      pr_q        <= pr_d;
      line_base_q <= line_base_d;
      rdaddr_q    <= rdaddr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Undelayed timing of the current counters (inactive while IDLE).
  // ---------------------------------------------------------------------------
  logic run_s;
  logic hs_raw_s;
  logic vs_raw_s;
  logic de_raw_s;

  assign run_s = (state_q == ST_RUN);

  // Raw sync / draw-area decode of the current counter position.
  always_comb begin
    if (run_s && in_window(x_q, HS_START, HS_LEN)) begin
      hs_raw_s = HSYNC_POL;
    end else begin
      hs_raw_s = ~HSYNC_POL;
    end
    if (run_s && in_window(y_q, VS_START, VS_LEN)) begin
      vs_raw_s = VSYNC_POL;
    end else begin
      vs_raw_s = ~VSYNC_POL;
    end
    de_raw_s = run_s && (x_q < H_ACT_C) && (y_q < V_ACT_C);
  end

  sync_delay #(
    .DEPTH   (RD_LATENCY),
    .HS_IDLE (~HSYNC_POL),
    .VS_IDLE (~VSYNC_POL)
  ) u_sync_delay (
    .clock_i (clock),
    .rst_ni  (rst_int_n),
    .hs_i    (hs_raw_s),
    .vs_i    (vs_raw_s),
    .de_i    (de_raw_s),
    .hs_o    (hsync),
    .vs_o    (vsync),
    .de_o    (DrawArea)
  );

  assign counterX    = x_q;
  assign counterY    = y_q;
  assign frame_start = fs_q;
  assign rdaddr      = rdaddr_q;

endmodule
